// File: rtl/mdio_c45_reg_bridge.sv
// Clause-45 MDIO backend: turns decoded MDIO frames into held valid/ready register-bus transactions.
// Owns the MMD pointer, post-increment, MMD enable mask and the ready timeout.
module mdio_c45_reg_bridge #(
  parameter int          DEV_W    = 5,
  parameter int          REG_W    = 16,
  parameter int          DATA_W   = 16,
  parameter logic [31:0] DEV_MASK = 32'hFFFF_FFFF,
  parameter int          TIMEOUT  = 255,
  parameter bit          WR_INCR  = 1'b0
) (
  input  logic                   clk_25m,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [13:0]            in_info,
  input  logic                   in_info_en,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_data_en,
  input  logic [DATA_W-1:0]      reg_if_rdata,
  input  logic                   reg_if_ready,
  output logic [DEV_W+REG_W-1:0] reg_if_addr,
  output logic [DATA_W-1:0]      reg_if_wdata,
  output logic                   reg_if_valid,
  output logic                   reg_if_we,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_ready,
  output logic                   resp_err,
  output logic                   busy
);
  localparam int              TO_W    = 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_WDATA, S_REQ} state_t;
  typedef enum logic [1:0] {OP_ADDR = 2'b00, OP_WR = 2'b01, OP_RD_INCR = 2'b10, OP_RD = 2'b11} op_t;

  state_t            r_state,      w_state_nxt;
  op_t               r_op,         w_op_nxt;
  logic [DEV_W-1:0]  r_devad,      w_devad_nxt;
  logic [REG_W-1:0]  r_ptr,        w_ptr_nxt;
  logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
  logic              r_valid,      w_valid_nxt;
  logic              r_we,         w_we_nxt;
  logic              r_reject,     w_reject_nxt;
  logic [TO_W-1:0]   r_cnt,        w_cnt_nxt;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic              r_resp_ready, w_resp_ready_nxt;
  logic              r_resp_err,   w_resp_err_nxt;
  logic              r_busy;

  op_t              w_info_op;
  logic [DEV_W-1:0] w_info_devad;
  logic             w_info_ok;
  logic             w_is_read;
  logic             w_incr;
  logic             w_unused_info;

  assign w_info_op     = op_t'(in_info[11:10]);
  assign w_info_devad  = in_info[DEV_W-1:0];
  assign w_info_ok     = DEV_MASK[w_info_devad];
  assign w_is_read     = (r_op == OP_RD) || (r_op == OP_RD_INCR);
  assign w_incr        = (r_op == OP_RD_INCR) || (WR_INCR && (r_op == OP_WR));
  assign w_unused_info = ^in_info;

  // NOTE: every variable gets its hold/default value first, so no path through the case leaves one unassigned.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_devad_nxt      = r_devad;
    w_ptr_nxt        = r_ptr;
    w_wdata_nxt      = r_wdata;
    w_valid_nxt      = r_valid;
    w_we_nxt         = r_we;
    w_reject_nxt     = r_reject;
    w_cnt_nxt        = r_cnt;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_ready_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;

    if (!enable) begin
      w_state_nxt      = S_IDLE;
      w_op_nxt         = OP_ADDR;
      w_devad_nxt      = '0;
      w_ptr_nxt        = '0;
      w_wdata_nxt      = '0;
      w_valid_nxt      = 1'b0;
      w_we_nxt         = 1'b0;
      w_reject_nxt     = 1'b0;
      w_cnt_nxt        = '0;
      w_resp_rdata_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_WAIT_WDATA: begin
          if (in_info_en) begin
            // A fresh info strobe always restarts decode; a pending frame is dropped.
            w_op_nxt     = w_info_op;
            w_devad_nxt  = w_info_devad;
            w_reject_nxt = !w_info_ok;
            if (w_info_op == OP_ADDR || w_info_op == OP_WR) begin
              w_state_nxt = S_WAIT_WDATA;
            end else if (w_info_ok) begin
              w_state_nxt = S_REQ;
              w_valid_nxt = 1'b1;
              w_we_nxt    = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt      = S_IDLE;
              w_resp_ready_nxt = 1'b1;
              w_resp_err_nxt   = 1'b1;
              w_resp_rdata_nxt = '1;
            end
          end else if (r_state == S_WAIT_WDATA && in_data_en) begin
            w_state_nxt = S_IDLE;
            if (!r_reject) begin
              if (r_op == OP_ADDR) begin
                w_ptr_nxt = in_data[REG_W-1:0];
              end else begin
                w_state_nxt = S_REQ;
                w_wdata_nxt = in_data;
                w_valid_nxt = 1'b1;
                w_we_nxt    = 1'b1;
                w_cnt_nxt   = '0;
              end
            end
          end
        end
        S_REQ: begin
          // Ready on the terminal timeout cycle still completes normally.
          if (reg_if_ready) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_we_nxt    = 1'b0;
            if (w_is_read) begin
              w_resp_ready_nxt = 1'b1;
              w_resp_rdata_nxt = reg_if_rdata;
            end
            if (w_incr) w_ptr_nxt = r_ptr + REG_W'(1);
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_we_nxt    = 1'b0;
            if (w_is_read) begin
              w_resp_ready_nxt = 1'b1;
              w_resp_err_nxt   = 1'b1;
              w_resp_rdata_nxt = '1;
            end
          end else begin
            w_cnt_nxt = r_cnt + TO_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_ADDR;
      r_devad      <= '0;
      r_ptr        <= '0;
      r_wdata      <= '0;
      r_valid      <= 1'b0;
      r_we         <= 1'b0;
      r_reject     <= 1'b0;
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_resp_ready <= 1'b0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_devad      <= w_devad_nxt;
      r_ptr        <= w_ptr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_valid      <= w_valid_nxt;
      r_we         <= w_we_nxt;
      r_reject     <= w_reject_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_ready <= w_resp_ready_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign reg_if_addr  = {r_devad, r_ptr};
  assign reg_if_wdata = r_wdata;
  assign reg_if_valid = r_valid;
  assign reg_if_we    = r_we;
  assign resp_rdata   = r_resp_rdata;
  assign resp_ready   = r_resp_ready;
  assign resp_err     = r_resp_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mdio_c45_reg_bridge.sv
// Self-checking bench for mdio_c45_reg_bridge: directed scenarios plus random frames against a
// transaction-level model (pointer/devad state, expected valid length = min(delay+1, TIMEOUT)).
module tb_mdio_c45_reg_bridge;
  localparam int          DEV_W   = 5;
  localparam int          REG_W   = 16;
  localparam int          DATA_W  = 16;
  localparam int          TB_TO   = 4;
  localparam logic [31:0] TB_MASK = 32'hFFFF_FF7E;
  localparam logic [1:0]  OP_ADDR = 2'b00, OP_WR = 2'b01, OP_RDINC = 2'b10, OP_RD = 2'b11;

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [13:0] in_info = '0;
  logic        in_info_en = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_data_en = 1'b0;
  logic [15:0] reg_if_rdata = '0;
  logic        reg_if_ready = 1'b0;

  logic [20:0] reg_if_addr, b_reg_if_addr;
  logic [15:0] reg_if_wdata, b_reg_if_wdata, resp_rdata, b_resp_rdata;
  logic        reg_if_valid, b_reg_if_valid, reg_if_we, b_reg_if_we;
  logic        resp_ready, b_resp_ready, resp_err, b_resp_err, busy, b_busy;

  int total = 0;
  int bad   = 0;
  logic [4:0]  m_devad = '0;
  logic [15:0] m_ptr   = '0;

  mdio_c45_reg_bridge #(.DEV_W(DEV_W), .REG_W(REG_W), .DATA_W(DATA_W), .DEV_MASK(TB_MASK),
                        .TIMEOUT(TB_TO), .WR_INCR(1'b1)) dut (
    .clk_25m(clk_25m), .rst(rst), .enable(enable), .in_info(in_info), .in_info_en(in_info_en),
    .in_data(in_data), .in_data_en(in_data_en), .reg_if_rdata(reg_if_rdata), .reg_if_ready(reg_if_ready),
    .reg_if_addr(reg_if_addr), .reg_if_wdata(reg_if_wdata), .reg_if_valid(reg_if_valid), .reg_if_we(reg_if_we),
    .resp_rdata(resp_rdata), .resp_ready(resp_ready), .resp_err(resp_err), .busy(busy));

  mdio_c45_reg_bridge #(.DEV_W(DEV_W), .REG_W(REG_W), .DATA_W(DATA_W), .DEV_MASK(TB_MASK),
                        .TIMEOUT(TB_TO), .WR_INCR(1'b0)) dut_noinc (
    .clk_25m(clk_25m), .rst(rst), .enable(enable), .in_info(in_info), .in_info_en(in_info_en),
    .in_data(in_data), .in_data_en(in_data_en), .reg_if_rdata(reg_if_rdata), .reg_if_ready(reg_if_ready),
    .reg_if_addr(b_reg_if_addr), .reg_if_wdata(b_reg_if_wdata), .reg_if_valid(b_reg_if_valid),
    .reg_if_we(b_reg_if_we), .resp_rdata(b_resp_rdata), .resp_ready(b_resp_ready), .resp_err(b_resp_err),
    .busy(b_busy));

  always #20 clk_25m = ~clk_25m;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [20:0] m_addr();
    return {m_devad, m_ptr};
  endfunction

  function automatic int exp_vcycles(input int delay);
    return (delay < TB_TO) ? delay + 1 : TB_TO;
  endfunction

  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic send_info(input logic [1:0] op, input logic [4:0] dev);
    in_info    = {2'($urandom), op, 5'($urandom), dev};
    in_info_en = 1'b1;
    step();
    in_info_en = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d);
    in_data    = d;
    in_data_en = 1'b1;
    step();
    in_data_en = 1'b0;
  endtask

  task automatic send_both(input logic [1:0] op, input logic [4:0] dev, input logic [15:0] d);
    in_info    = {2'b00, op, 5'b00000, dev};
    in_data    = d;
    in_info_en = 1'b1;
    in_data_en = 1'b1;
    step();
    in_info_en = 1'b0;
    in_data_en = 1'b0;
  endtask

  // Serves an outstanding request: ready pulses on valid cycle index 'delay' (0-based).
  task automatic run_req(input int delay, input logic [15:0] rdata, output int vc, output logic [20:0] a0,
                         output logic moved, output logic rr, output logic re, output logic [15:0] rd);
    logic        we0;
    logic [15:0] wd0;
    vc = 0; moved = 1'b0; a0 = reg_if_addr; we0 = reg_if_we; wd0 = reg_if_wdata;
    for (int c = 0; c < 300 && reg_if_valid === 1'b1; c++) begin
      vc++;
      if (reg_if_addr !== a0 || reg_if_we !== we0 || reg_if_wdata !== wd0) moved = 1'b1;
      reg_if_ready = (c == delay);
      reg_if_rdata = (c == delay) ? rdata : 16'($urandom);
      step();
    end
    reg_if_ready = 1'b0;
    rr = resp_ready; re = resp_err; rd = resp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (2) step();
    total++; if ({reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we, resp_rdata, resp_ready, resp_err, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs: got addr=%h wdata=%h valid=%b we=%b rdata=%h rr=%b err=%b busy=%b exp all 0",
                      reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we, resp_rdata, resp_ready, resp_err, busy);
    end
    rst = 1'b0; step();
    enable = 1'b1; step();
    total++; if ({reg_if_addr, reg_if_valid, resp_ready, busy} !== '0) begin
      bad++; $display("FAIL reset_release: got addr=%h valid=%b rr=%b busy=%b exp 0", reg_if_addr, reg_if_valid, resp_ready, busy);
    end
    m_devad = '0; m_ptr = '0;
  endtask

  task automatic test_addr_read();
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    send_info(OP_ADDR, 5'd3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL addr_busy: got %b exp 1", busy); end
    send_data(16'h0010);
    m_devad = 5'd3; m_ptr = 16'h0010;
    total++; if ({busy, reg_if_valid, reg_if_addr} !== {2'b00, m_addr()}) begin
      bad++; $display("FAIL addr_set: got busy=%b valid=%b addr=%h exp 0 0 %h", busy, reg_if_valid, reg_if_addr, m_addr());
    end
    send_info(OP_RD, 5'd3);
    total++; if ({reg_if_valid, reg_if_we, reg_if_addr} !== {2'b10, 21'h030010}) begin
      bad++; $display("FAIL rd_launch: got valid=%b we=%b addr=%h exp 1 0 030010", reg_if_valid, reg_if_we, reg_if_addr);
    end
    run_req(2, 16'hBEEF, vc, a0, mv, rr, re, rd);
    total++; if (vc !== 3 || mv !== 1'b0) begin bad++; $display("FAIL rd_valid_len: got %0d moved=%b exp 3 0", vc, mv); end
    total++; if ({rr, re, rd} !== {2'b10, 16'hBEEF}) begin
      bad++; $display("FAIL rd_resp: got rr=%b err=%b rdata=%h exp 1 0 beef", rr, re, rd);
    end
    step();
    total++; if ({resp_ready, reg_if_addr, busy} !== {1'b0, 21'h030010, 1'b0}) begin
      bad++; $display("FAIL rd_after: got rr=%b addr=%h busy=%b exp 0 030010 0", resp_ready, reg_if_addr, busy);
    end
  endtask

  task automatic test_rd_incr_wrap();
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    send_info(OP_ADDR, 5'd9); send_data(16'hFFFF);
    m_devad = 5'd9; m_ptr = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      send_info(OP_RDINC, 5'd9);
      run_req(1, 16'h1000 + 16'(k), vc, a0, mv, rr, re, rd);
      total++; if ({a0, mv} !== {m_addr(), 1'b0}) begin
        bad++; $display("FAIL rdinc_addr%0d: got %h moved=%b exp %h 0", k, a0, mv, m_addr());
      end
      m_ptr = m_ptr + 16'd1;
      total++; if ({reg_if_addr, rr, re, rd} !== {m_addr(), 2'b10, 16'h1000 + 16'(k)}) begin
        bad++; $display("FAIL rdinc_after%0d: got addr=%h rr=%b err=%b rd=%h exp %h 1 0 %h", k, reg_if_addr, rr, re, rd,
                        m_addr(), 16'h1000 + 16'(k));
      end
      step();
    end
  endtask

  task automatic test_write_incr();
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    send_info(OP_ADDR, 5'd2); send_data(16'h0005);
    m_devad = 5'd2; m_ptr = 16'h0005;
    send_info(OP_WR, 5'd2); send_data(16'h1234);
    total++; if ({reg_if_valid, reg_if_we, reg_if_wdata, reg_if_addr} !== {2'b11, 16'h1234, 21'h020005}) begin
      bad++; $display("FAIL wr_launch: got valid=%b we=%b wdata=%h addr=%h exp 1 1 1234 020005",
                      reg_if_valid, reg_if_we, reg_if_wdata, reg_if_addr);
    end
    total++; if ({b_reg_if_valid, b_reg_if_we, b_reg_if_wdata} !== {2'b11, 16'h1234}) begin
      bad++; $display("FAIL wr_launch_noinc: got valid=%b we=%b wdata=%h exp 1 1 1234", b_reg_if_valid, b_reg_if_we, b_reg_if_wdata);
    end
    run_req(1, 16'h0, vc, a0, mv, rr, re, rd);
    total++; if (vc !== 2 || mv !== 1'b0 || rr !== 1'b0 || b_resp_ready !== 1'b0) begin
      bad++; $display("FAIL wr_handshake: got vc=%0d moved=%b rr=%b rr_noinc=%b exp 2 0 0 0", vc, mv, rr, b_resp_ready);
    end
    m_ptr = 16'h0006;
    total++; if (reg_if_addr !== 21'h020006 || b_reg_if_addr !== 21'h020005) begin
      bad++; $display("FAIL wr_ptr: got incr=%h noinc=%h exp 020006 020005", reg_if_addr, b_reg_if_addr);
    end
    step();
  endtask

  task automatic test_timeout();
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    send_info(OP_ADDR, 5'd4); send_data(16'h0100);
    m_devad = 5'd4; m_ptr = 16'h0100;
    send_info(OP_RDINC, 5'd4);
    run_req(1000, 16'h0, vc, a0, mv, rr, re, rd);
    total++; if (vc !== TB_TO) begin bad++; $display("FAIL to_len: got %0d exp %0d", vc, TB_TO); end
    total++; if ({rr, re, rd, reg_if_addr} !== {2'b11, 16'hFFFF, m_addr()}) begin
      bad++; $display("FAIL to_resp: got rr=%b err=%b rd=%h addr=%h exp 1 1 ffff %h", rr, re, rd, reg_if_addr, m_addr());
    end
    step();
    send_info(OP_RDINC, 5'd4);
    run_req(TB_TO - 1, 16'h5A5A, vc, a0, mv, rr, re, rd);
    m_ptr = m_ptr + 16'd1;
    total++; if ({vc == TB_TO, rr, re, rd, reg_if_addr} !== {3'b110, 16'h5A5A, m_addr()}) begin
      bad++; $display("FAIL to_last_ready: got vc=%0d rr=%b err=%b rd=%h addr=%h exp %0d 1 0 5a5a %h",
                      vc, rr, re, rd, reg_if_addr, TB_TO, m_addr());
    end
    step();
    send_info(OP_WR, 5'd4); send_data(16'hCAFE);
    run_req(1000, 16'h0, vc, a0, mv, rr, re, rd);
    total++; if ({vc == TB_TO, rr, reg_if_addr} !== {2'b10, m_addr()}) begin
      bad++; $display("FAIL to_wr: got vc=%0d rr=%b addr=%h exp %0d 0 %h", vc, rr, reg_if_addr, TB_TO, m_addr());
    end
    step();
  endtask

  task automatic test_reject();
    logic [15:0] keep;
    send_info(OP_RD, 5'd0);
    m_devad = 5'd0;
    total++; if ({reg_if_valid, resp_ready, resp_err, resp_rdata, busy} !== {3'b011, 16'hFFFF, 1'b0}) begin
      bad++; $display("FAIL rej_rd: got valid=%b rr=%b err=%b rd=%h busy=%b exp 0 1 1 ffff 0",
                      reg_if_valid, resp_ready, resp_err, resp_rdata, busy);
    end
    step();
    total++; if (resp_ready !== 1'b0) begin bad++; $display("FAIL rej_pulse: got %b exp 0", resp_ready); end
    keep = m_ptr;
    send_info(OP_ADDR, 5'd7); send_data(16'h0055);
    m_devad = 5'd7;
    total++; if (reg_if_addr !== {5'd7, keep}) begin
      bad++; $display("FAIL rej_addr: got %h exp %h", reg_if_addr, {5'd7, keep});
    end
    send_info(OP_WR, 5'd0); send_data(16'h7777);
    m_devad = 5'd0;
    total++; if ({reg_if_valid, resp_ready, busy} !== 3'b000) begin
      bad++; $display("FAIL rej_wr: got valid=%b rr=%b busy=%b exp 0 0 0", reg_if_valid, resp_ready, busy);
    end
  endtask

  task automatic test_strobe_rules();
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    send_info(OP_ADDR, 5'd1); send_data(16'h0A00);
    m_devad = 5'd1; m_ptr = 16'h0A00;
    send_info(OP_WR, 5'd1); send_info(OP_RD, 5'd1);
    total++; if ({reg_if_valid, reg_if_we} !== 2'b10) begin
      bad++; $display("FAIL restart: got valid=%b we=%b exp 1 0", reg_if_valid, reg_if_we);
    end
    run_req(0, 16'h1111, vc, a0, mv, rr, re, rd);
    step();
    send_info(OP_ADDR, 5'd1);
    send_both(OP_RD, 5'd1, 16'hAAAA);
    total++; if ({reg_if_valid, reg_if_we, reg_if_addr} !== {2'b10, m_addr()}) begin
      bad++; $display("FAIL info_over_data: got valid=%b we=%b addr=%h exp 1 0 %h", reg_if_valid, reg_if_we, reg_if_addr, m_addr());
    end
    run_req(0, 16'h2222, vc, a0, mv, rr, re, rd);
    step();
    send_info(OP_RD, 5'd1);
    send_both(OP_ADDR, 5'd6, 16'h3333);
    run_req(0, 16'h4444, vc, a0, mv, rr, re, rd);
    total++; if ({rr, re, rd, reg_if_addr, busy} !== {2'b10, 16'h4444, m_addr(), 1'b0}) begin
      bad++; $display("FAIL req_ignores_strobes: got rr=%b err=%b rd=%h addr=%h busy=%b exp 1 0 4444 %h 0",
                      rr, re, rd, reg_if_addr, busy, m_addr());
    end
    send_data(16'h5555);
    total++; if ({reg_if_addr, busy} !== {m_addr(), 1'b0}) begin
      bad++; $display("FAIL idle_data_ignored: got addr=%h busy=%b exp %h 0", reg_if_addr, busy, m_addr());
    end
  endtask

  task automatic test_enable_abort();
    send_info(OP_ADDR, 5'd3); send_data(16'h0042);
    send_info(OP_RD, 5'd3);
    enable = 1'b0;
    step();
    enable = 1'b1;
    m_devad = '0; m_ptr = '0;
    total++; if ({reg_if_valid, reg_if_we, reg_if_addr, busy, resp_ready} !== '0) begin
      bad++; $display("FAIL abort: got valid=%b we=%b addr=%h busy=%b rr=%b exp all 0", reg_if_valid, reg_if_we, reg_if_addr, busy, resp_ready);
    end
    reg_if_ready = 1'b1; reg_if_rdata = 16'hDEAD;
    step();
    reg_if_ready = 1'b0;
    step();
    total++; if ({resp_ready, reg_if_valid} !== 2'b00) begin
      bad++; $display("FAIL late_ready: got rr=%b valid=%b exp 0 0", resp_ready, reg_if_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_info(OP_ADDR, 5'd5); send_data(16'h0077);
    send_info(OP_RD, 5'd5);
    #5 rst = 1'b1;
    #1;
    total++; if ({reg_if_valid, reg_if_addr, busy} !== '0) begin
      bad++; $display("FAIL async_reset: got valid=%b addr=%h busy=%b exp 0", reg_if_valid, reg_if_addr, busy);
    end
    #5 rst = 1'b0;
    step();
    m_devad = '0; m_ptr = '0;
  endtask

  task automatic test_random();
    logic [1:0] op; logic [4:0] dev; logic [15:0] data, rdata; int delay; logic ok;
    int vc; logic [20:0] a0; logic mv, rr, re; logic [15:0] rd;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom); dev = 5'($urandom_range(0, 9)); data = 16'($urandom);
      rdata = 16'($urandom); delay = $urandom_range(0, 5); ok = TB_MASK[dev];
      send_info(op, dev);
      m_devad = dev;
      if (op == OP_ADDR || op == OP_WR) begin
        send_data(data);
        if (op == OP_ADDR) begin
          if (ok) m_ptr = data;
          total++; if ({reg_if_valid, reg_if_addr} !== {1'b0, m_addr()}) begin
            bad++; $display("FAIL rnd%0d_addr: got valid=%b addr=%h exp 0 %h", k, reg_if_valid, reg_if_addr, m_addr());
          end
        end else if (!ok) begin
          total++; if ({reg_if_valid, resp_ready} !== 2'b00) begin
            bad++; $display("FAIL rnd%0d_wr_rej: got valid=%b rr=%b exp 0 0", k, reg_if_valid, resp_ready);
          end
        end else begin
          total++; if ({reg_if_valid, reg_if_we, reg_if_wdata, reg_if_addr} !== {2'b11, data, m_addr()}) begin
            bad++; $display("FAIL rnd%0d_wr_req: got valid=%b we=%b wdata=%h addr=%h exp 1 1 %h %h",
                            k, reg_if_valid, reg_if_we, reg_if_wdata, reg_if_addr, data, m_addr());
          end
          run_req(delay, rdata, vc, a0, mv, rr, re, rd);
          total++; if (vc !== exp_vcycles(delay) || mv !== 1'b0 || rr !== 1'b0) begin
            bad++; $display("FAIL rnd%0d_wr_hs: got vc=%0d moved=%b rr=%b exp %0d 0 0", k, vc, mv, rr, exp_vcycles(delay));
          end
          if (delay < TB_TO) m_ptr = m_ptr + 16'd1;
        end
      end else if (!ok) begin
        total++; if ({reg_if_valid, resp_ready, resp_err, resp_rdata} !== {3'b011, 16'hFFFF}) begin
          bad++; $display("FAIL rnd%0d_rd_rej: got valid=%b rr=%b err=%b rd=%h exp 0 1 1 ffff",
                          k, reg_if_valid, resp_ready, resp_err, resp_rdata);
        end
      end else begin
        total++; if ({reg_if_valid, reg_if_we, reg_if_addr} !== {2'b10, m_addr()}) begin
          bad++; $display("FAIL rnd%0d_rd_req: got valid=%b we=%b addr=%h exp 1 0 %h", k, reg_if_valid, reg_if_we, reg_if_addr, m_addr());
        end
        run_req(delay, rdata, vc, a0, mv, rr, re, rd);
        total++; if (vc !== exp_vcycles(delay) || mv !== 1'b0 ||
                     {rr, re, rd} !== {1'b1, delay >= TB_TO, (delay >= TB_TO) ? 16'hFFFF : rdata}) begin
          bad++; $display("FAIL rnd%0d_rd_resp: got vc=%0d moved=%b rr=%b err=%b rd=%h exp %0d 0 1 %b %h", k, vc, mv, rr, re, rd,
                          exp_vcycles(delay), delay >= TB_TO, (delay >= TB_TO) ? 16'hFFFF : rdata);
        end
        if (op == OP_RDINC && delay < TB_TO) m_ptr = m_ptr + 16'd1;
      end
      reg_if_ready = 1'($urandom);
      step();
      reg_if_ready = 1'b0;
      total++; if ({resp_ready, reg_if_valid, busy, reg_if_addr} !== {3'b000, m_addr()}) begin
        bad++; $display("FAIL rnd%0d_idle: got rr=%b valid=%b busy=%b addr=%h exp 0 0 0 %h",
                        k, resp_ready, reg_if_valid, busy, reg_if_addr, m_addr());
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_read();
    test_rd_incr_wrap();
    test_write_incr();
    test_timeout();
    test_reject();
    test_strobe_rules();
    test_enable_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
